write_word_sched: RTL and testbench

Read-modify-write scheduler for single-word writes into the SAM block RAM. Arbitrates between two requesters, reads the addressed row from BRAM, and sequences the `WriteWord` patch datapath through PREPARE and UPDATE. It then commits the patched row back to BRAM and acknowledges the winning requester. It sits between the search/insert engines and the BRAM port owned by `samControl`.

---
 rtl/write_word_sched_pkg.sv | 37 +++
 rtl/WriteWord.sv | 63 ++++++
 rtl/write_word_sched.sv | 173 +++++++++++++++++
 tb/tb_write_word_sched.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/write_word_sched_pkg.sv
// -----------------------------------------------------------------------------
// write_word_sched_pkg
//
// Shared definitions for the SAM single-word read-modify-write path.
//   - Default widths of a BRAM row, a word, the in-row word index and the
//     BRAM row address.
//   - Command codes that step the WriteWord patch datapath.
//   - State encoding of the write_word_sched sequencer.
// -----------------------------------------------------------------------------
package write_word_sched_pkg;

    // Default geometry: 32 words of 32 bits per BRAM row, 1024 rows.
    localparam int SAM_TGT_BITS      = 32;
    localparam int SAM_BRAM_ADR_BITS = 5;
    localparam int SAM_ROW_ADR_BITS  = 10;
    localparam int SAM_WORDS         = 1 << SAM_BRAM_ADR_BITS;
    localparam int SAM_ROW_BITS      = SAM_WORDS * SAM_TGT_BITS;

    // Commands understood by WriteWord.
    typedef enum logic [1:0] {
        WR_IDLE    = 2'b00,
        WR_PREPARE = 2'b01,
        WR_UPDATE  = 2'b10,
        WR_COMMIT  = 2'b11
    } wryt_go_t;

    // Sequencer states.
    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        PREP,
        UPD,
        COMMIT
    } sched_state_t;

endpackage

// File: rtl/WriteWord.sv
// -----------------------------------------------------------------------------
// WriteWord
//
// Patch datapath for one BRAM row. PREPARE captures the row read from BRAM,
// UPDATE overwrites one word of the captured row, and the patched row is then
// presented on rowOut for the write-back. IDLE and COMMIT hold the row.
//
// Ports:
//   clk      in   clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   wrytGo   in   command (WR_IDLE / WR_PREPARE / WR_UPDATE / WR_COMMIT)
//   rowIn    in   row captured on WR_PREPARE
//   wdAdr    in   index of the word replaced on WR_UPDATE
//   target   in   new value of that word
//   rowOut   out  captured (and possibly patched) row
// -----------------------------------------------------------------------------
module WriteWord
    import write_word_sched_pkg::*;
#(
    parameter int TGT_BITS      = SAM_TGT_BITS,
    parameter int BRAM_ADR_BITS = SAM_BRAM_ADR_BITS,
    parameter int ROW_BITS      = SAM_ROW_BITS
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [1:0]               wrytGo,
    input  logic [ROW_BITS-1:0]      rowIn,
    input  logic [BRAM_ADR_BITS-1:0] wdAdr,
    input  logic [TGT_BITS-1:0]      target,
    output logic [ROW_BITS-1:0]      rowOut
);

    localparam int WORDS = ROW_BITS / TGT_BITS;

    logic [ROW_BITS-1:0] row_q;
    logic [ROW_BITS-1:0] patched;

    // Word-select mux: exactly one word slot takes the target value, every
    // other slot passes through untouched.
    always_comb begin
        patched = row_q;
        for (int w = 0; w < WORDS; w++) begin
            if (wdAdr == BRAM_ADR_BITS'(w)) begin
                patched[w*TGT_BITS +: TGT_BITS] = target;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_q <= '0;
        end else begin
            case (wrytGo)
                WR_PREPARE: row_q <= rowIn;
                WR_UPDATE:  row_q <= patched;
                default:    row_q <= row_q;
            endcase
        end
    end

    assign rowOut = row_q;

endmodule

// File: rtl/write_word_sched.sv
// -----------------------------------------------------------------------------
// write_word_sched
//
// Read-modify-write scheduler for single-word writes into the SAM BRAM.
// Two requesters are arbitrated round-robin; the winner's row is read,
// patched through WriteWord and written back, then the winner gets a
// one-cycle done pulse. One write takes RD_LAT+4 cycles, accept to accept.
//
// Ports:
//   clk         in   clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   req_valid   in   [2]  per-requester write request
//   req_ready   out  [2]  one-hot accept strobe (combinational in IDLE)
//   req_row     in   [2*ROW_ADR_BITS]  row address, slice i for requester i
//   req_wd      in   [2*BRAM_ADR_BITS] word index, slice i for requester i
//   req_tgt     in   [2*TGT_BITS]      word value, slice i for requester i
//   req_done    out  [2]  completion pulse to the accepted requester
//   busy        out  high while a write is in flight (READ..COMMIT)
//   bram_re     out  BRAM read strobe
//   bram_we     out  BRAM write strobe
//   bram_adr    out  BRAM row address for read and write
//   bram_rdata  in   BRAM read data, valid RD_LAT cycles after bram_re
//   bram_wdata  out  patched row from WriteWord
// -----------------------------------------------------------------------------
module write_word_sched
    import write_word_sched_pkg::*;
#(
    parameter int TGT_BITS      = SAM_TGT_BITS,
    parameter int BRAM_ADR_BITS = SAM_BRAM_ADR_BITS,
    parameter int ROW_ADR_BITS  = SAM_ROW_ADR_BITS,
    parameter int ROW_BITS      = 32 * TGT_BITS,
    parameter int RD_LAT        = 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [1:0]                 req_valid,
    output logic [1:0]                 req_ready,
    input  logic [2*ROW_ADR_BITS-1:0]  req_row,
    input  logic [2*BRAM_ADR_BITS-1:0] req_wd,
    input  logic [2*TGT_BITS-1:0]      req_tgt,
    output logic [1:0]                 req_done,
    output logic                       busy,
    output logic                       bram_re,
    output logic                       bram_we,
    output logic [ROW_ADR_BITS-1:0]    bram_adr,
    input  logic [ROW_BITS-1:0]        bram_rdata,
    output logic [ROW_BITS-1:0]        bram_wdata
);

    // WAIT covers RD_LAT-1 cycles; the counter starts at 0 in the first
    // WAIT cycle, so it leaves on the value RD_LAT-2.
    localparam int         WAIT_LAST_INT = (RD_LAT > 1) ? RD_LAT - 2 : 0;
    localparam logic [1:0] WAIT_LAST     = 2'(WAIT_LAST_INT);

    sched_state_t state_q, state_d;

    logic [ROW_ADR_BITS-1:0]  row_q, row_d;
    logic [BRAM_ADR_BITS-1:0] wd_q, wd_d;
    logic [TGT_BITS-1:0]      tgt_q, tgt_d;
    logic                     owner_q, owner_d;
    logic                     last_q, last_d;
    logic [1:0]               cnt_q, cnt_d;

    logic [1:0] grant;
    logic       gidx;
    logic [1:0] wryt_go;

    // State and request registers. The round-robin pointer comes out of
    // reset pointing at requester 1 so that requester 0 wins the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            wd_q    <= '0;
            tgt_q   <= '0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            wd_q    <= wd_d;
            tgt_q   <= tgt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Arbiter and sequencer. Requests are only looked at in IDLE, so a
    // request raised while busy simply waits. The pointer moves to the
    // owner only when the write commits; an aborted write leaves it alone.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        wd_d    = wd_q;
        tgt_d   = tgt_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        grant   = 2'b00;
        gidx    = 1'b0;
        wryt_go = WR_IDLE;

        case (state_q)
            IDLE: begin
                if ((|req_valid) && reset_n) begin
                    gidx    = (req_valid == 2'b11) ? ~last_q : req_valid[1];
                    grant   = gidx ? 2'b10 : 2'b01;
                    owner_d = gidx;
                    row_d   = gidx ? req_row[2*ROW_ADR_BITS-1 -: ROW_ADR_BITS]
                                   : req_row[ROW_ADR_BITS-1:0];
                    wd_d    = gidx ? req_wd[2*BRAM_ADR_BITS-1 -: BRAM_ADR_BITS]
                                   : req_wd[BRAM_ADR_BITS-1:0];
                    tgt_d   = gidx ? req_tgt[2*TGT_BITS-1 -: TGT_BITS]
                                   : req_tgt[TGT_BITS-1:0];
                    state_d = READ;
                end
            end
            READ: begin
                cnt_d   = 2'd0;
                state_d = (RD_LAT > 1) ? WAIT : PREP;
            end
            WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = PREP;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            PREP: begin
                wryt_go = WR_PREPARE;
                state_d = UPD;
            end
            UPD: begin
                wryt_go = WR_UPDATE;
                state_d = COMMIT;
            end
            COMMIT: begin
                wryt_go = WR_COMMIT;
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_ready = grant;
    assign busy      = (state_q != IDLE);
    assign bram_re   = (state_q == READ);
    assign bram_we   = (state_q == COMMIT);
    assign bram_adr  = row_q;
    assign req_done  = (state_q == COMMIT) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;

    // PREP captures bram_rdata, which is valid exactly then because PREP
    // sits RD_LAT cycles after READ.
    WriteWord #(
        .TGT_BITS      (TGT_BITS),
        .BRAM_ADR_BITS (BRAM_ADR_BITS),
        .ROW_BITS      (ROW_BITS)
    ) u_write_word (
        .clk     (clk),
        .reset_n (reset_n),
        .wrytGo  (wryt_go),
        .rowIn   (bram_rdata),
        .wdAdr   (wd_q),
        .target  (tgt_q),
        .rowOut  (bram_wdata)
    );

endmodule

// File: tb/tb_write_word_sched.sv
// -----------------------------------------------------------------------------
// tb_write_word_sched
//
// Two scheduler instances: "a" with RD_LAT=1 and "b" with RD_LAT=3, each with
// its own behavioural BRAM. A table of single-write vectors drives "a";
// contention, reset-in-flight and the slow-BRAM case are hand-written.
// -----------------------------------------------------------------------------
module tb_write_word_sched;

    localparam int TGT   = 32;
    localparam int WORDS = 32;
    localparam int ROWB  = TGT * WORDS;
    localparam int RADR  = 10;
    localparam int WADR  = 5;

    typedef struct {
        int              req;
        logic [RADR-1:0] row;
        logic [WADR-1:0] wd;
        logic [TGT-1:0]  tgt;
        logic [TGT-1:0]  fill;
        bit              preload;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;

    logic [1:0]        a_req_valid, a_req_ready, a_req_done;
    logic [2*RADR-1:0] a_req_row;
    logic [2*WADR-1:0] a_req_wd;
    logic [2*TGT-1:0]  a_req_tgt;
    logic              a_busy, a_re, a_we;
    logic [RADR-1:0]   a_adr;
    logic [ROWB-1:0]   a_rdata, a_wdata;

    logic [1:0]        b_req_valid, b_req_ready, b_req_done;
    logic [2*RADR-1:0] b_req_row;
    logic [2*WADR-1:0] b_req_wd;
    logic [2*TGT-1:0]  b_req_tgt;
    logic              b_busy, b_re, b_we;
    logic [RADR-1:0]   b_adr;
    logic [ROWB-1:0]   b_rdata, b_wdata, b_rd1, b_rd2;

    logic [ROWB-1:0] mem_a [0:1023];
    logic [ROWB-1:0] mem_b [0:1023];

    logic            pl_en;
    logic            pl_sel;
    logic [RADR-1:0] pl_row;
    logic [ROWB-1:0] pl_data;

    int a_we_cnt   = 0;
    int a_done_cnt = 0;

    int checks_total  = 0;
    int checks_passed = 0;

    logic [ROWB-1:0] exp_row;
    vec_t            vecs[7];

    write_word_sched #(.RD_LAT(1)) dut_a (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (a_req_valid),
        .req_ready  (a_req_ready),
        .req_row    (a_req_row),
        .req_wd     (a_req_wd),
        .req_tgt    (a_req_tgt),
        .req_done   (a_req_done),
        .busy       (a_busy),
        .bram_re    (a_re),
        .bram_we    (a_we),
        .bram_adr   (a_adr),
        .bram_rdata (a_rdata),
        .bram_wdata (a_wdata)
    );

    write_word_sched #(.RD_LAT(3)) dut_b (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (b_req_valid),
        .req_ready  (b_req_ready),
        .req_row    (b_req_row),
        .req_wd     (b_req_wd),
        .req_tgt    (b_req_tgt),
        .req_done   (b_req_done),
        .busy       (b_busy),
        .bram_re    (b_re),
        .bram_we    (b_we),
        .bram_adr   (b_adr),
        .bram_rdata (b_rdata),
        .bram_wdata (b_wdata)
    );

    always #5 clk = ~clk;

    // BRAM model for "a": one-cycle read, data forced to zero when not read.
    always @(posedge clk) begin
        if (pl_en && !pl_sel) mem_a[pl_row] <= pl_data;
        else if (a_we) mem_a[a_adr] <= a_wdata;
        a_rdata <= a_re ? mem_a[a_adr] : '0;
    end

    // BRAM model for "b": three-cycle read pipeline.
    always @(posedge clk) begin
        if (pl_en && pl_sel) mem_b[pl_row] <= pl_data;
        else if (b_we) mem_b[b_adr] <= b_wdata;
        b_rd1   <= b_re ? mem_b[b_adr] : '0;
        b_rd2   <= b_rd1;
        b_rdata <= b_rd2;
    end

    always @(posedge clk) begin
        if (a_we) a_we_cnt <= a_we_cnt + 1;
        if (a_req_done != 2'b00) a_done_cnt <= a_done_cnt + 1;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic checkRow(input string name, input logic [ROWB-1:0] act, input logic [ROWB-1:0] exp);
        int bad;
        checks_total++;
        if (act === exp) begin
            checks_passed++;
        end else begin
            bad = 0;
            for (int w = WORDS - 1; w >= 0; w--)
                if (act[w*TGT +: TGT] !== exp[w*TGT +: TGT]) bad = w;
            $display("[TB] FAIL %s: word %0d got %h, expected %h",
                     name, bad, act[bad*TGT +: TGT], exp[bad*TGT +: TGT]);
        end
    endtask

    task automatic failNow(input string name);
        checks_total++;
        $display("[TB] FAIL %s: event not seen within its cycle budget", name);
    endtask

    function automatic logic [ROWB-1:0] patchRow(input logic [ROWB-1:0] r, input logic [WADR-1:0] wd,
                                                 input logic [TGT-1:0] tgt);
        logic [ROWB-1:0] o;
        o = r;
        o[int'(wd)*TGT +: TGT] = tgt;
        return o;
    endfunction

    task automatic preloadRow(input logic sel, input logic [RADR-1:0] row, input logic [TGT-1:0] fill);
        @(negedge clk);
        pl_sel  = sel;
        pl_row  = row;
        pl_data = {WORDS{fill}};
        pl_en   = 1'b1;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    // Called at a negedge with a request already driven; returns at the
    // accept cycle (sampled #1 after the negedge) or reports a timeout.
    task automatic waitAcceptA(input int req, output bit got);
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            #1;
            if (a_req_ready[req]) got = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        bit         got;
        logic [1:0] oh;
        oh = (v.req == 1) ? 2'b10 : 2'b01;
        if (v.preload) begin
            preloadRow(1'b0, v.row, v.fill);
            exp_row = {WORDS{v.fill}};
        end
        exp_row = patchRow(exp_row, v.wd, v.tgt);
        @(negedge clk);
        a_req_row[v.req*RADR +: RADR] = v.row;
        a_req_wd[v.req*WADR +: WADR]  = v.wd;
        a_req_tgt[v.req*TGT +: TGT]   = v.tgt;
        a_req_valid[v.req]            = 1'b1;
        waitAcceptA(v.req, got);
        if (!got) begin
            failNow("vec accept");
            a_req_valid = 2'b00;
            return;
        end
        checkOutput("vec ready onehot", 64'(a_req_ready), 64'(oh));
        @(negedge clk);
        a_req_valid = 2'b00;
        checkOutput("vec re at T+1", 64'(a_re), 64'd1);
        checkOutput("vec we at T+1", 64'(a_we), 64'd0);
        checkOutput("vec busy at T+1", 64'(a_busy), 64'd1);
        checkOutput("vec read adr", 64'(a_adr), 64'(v.row));
        @(negedge clk);
        checkOutput("vec re at T+2", 64'(a_re), 64'd0);
        @(negedge clk);
        checkOutput("vec we at T+3", 64'(a_we), 64'd0);
        checkOutput("vec done at T+3", 64'(a_req_done), 64'd0);
        @(negedge clk);
        checkOutput("vec we at T+4", 64'(a_we), 64'd1);
        checkOutput("vec done at T+4", 64'(a_req_done), 64'(oh));
        checkOutput("vec write adr", 64'(a_adr), 64'(v.row));
        checkRow("vec wdata", a_wdata, exp_row);
        @(negedge clk);
        checkOutput("vec busy at T+5", 64'(a_busy), 64'd0);
        checkRow("vec bram row", mem_a[v.row], exp_row);
    endtask

    task automatic pulseReset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic runContention();
        int ng;
        int nd;
        ng = 0;
        nd = 0;
        pulseReset();
        a_req_row   = {10'h021, 10'h020};
        a_req_wd    = {5'd2, 5'd1};
        a_req_tgt   = {32'h000000B1, 32'h000000A1};
        a_req_valid = 2'b11;
        for (int cyc = 0; cyc < 22; cyc++) begin
            #1;
            if (a_req_ready != 2'b00) begin
                checkOutput("contention grant id", 64'(a_req_ready), (ng % 2 == 1) ? 64'h2 : 64'h1);
                checkOutput("contention grant cycle", 64'(cyc), 64'(5 * ng));
                ng++;
            end
            if (a_req_done != 2'b00) begin
                checkOutput("contention done owner", 64'(a_req_done), (nd % 2 == 1) ? 64'h2 : 64'h1);
                checkOutput("contention done cycle", 64'(cyc), 64'(5 * nd + 4));
                nd++;
            end
            @(negedge clk);
        end
        a_req_valid = 2'b00;
        checkOutput("contention grant count", 64'(ng), 64'd5);
        checkOutput("contention done count", 64'(nd), 64'd4);
        repeat (6) @(negedge clk);
    endtask

    task automatic runResetMidWrite();
        bit got;
        int we_snap;
        int done_snap;
        preloadRow(1'b0, 10'h040, 32'h55555555);
        exp_row = {WORDS{32'h55555555}};
        @(negedge clk);
        a_req_row[RADR-1:0] = 10'h040;
        a_req_wd[WADR-1:0]  = 5'd9;
        a_req_tgt[TGT-1:0]  = 32'h99999999;
        a_req_valid         = 2'b01;
        waitAcceptA(0, got);
        if (!got) begin
            failNow("reset-mid accept");
            a_req_valid = 2'b00;
            return;
        end
        @(negedge clk);
        a_req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        we_snap   = a_we_cnt;
        done_snap = a_done_cnt;
        reset_n   = 1'b0;
        #1;
        checkOutput("reset-mid busy", 64'(a_busy), 64'd0);
        checkOutput("reset-mid we", 64'(a_we), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("reset-mid no write", 64'(a_we_cnt), 64'(we_snap));
        checkOutput("reset-mid no done", 64'(a_done_cnt), 64'(done_snap));
        checkRow("reset-mid row unchanged", mem_a[10'h040], exp_row);
    endtask

    task automatic runSlowBram();
        bit              got;
        int              re_cyc;
        int              we_cyc;
        logic [ROWB-1:0] exp_b;
        preloadRow(1'b1, 10'h00C, 32'h0F0F0F0F);
        exp_b = patchRow({WORDS{32'h0F0F0F0F}}, 5'd30, 32'hBADC0DE5);
        @(negedge clk);
        b_req_row[2*RADR-1 -: RADR] = 10'h00C;
        b_req_wd[2*WADR-1 -: WADR]  = 5'd30;
        b_req_tgt[2*TGT-1 -: TGT]   = 32'hBADC0DE5;
        b_req_valid                 = 2'b10;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            #1;
            if (b_req_ready[1]) got = 1'b1;
            else @(negedge clk);
        end
        if (!got) begin
            failNow("rdlat3 accept");
            b_req_valid = 2'b00;
            return;
        end
        re_cyc = -1;
        we_cyc = -1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) b_req_valid = 2'b00;
            if (b_re && re_cyc < 0) re_cyc = k;
            if (b_we && we_cyc < 0) begin
                we_cyc = k;
                checkOutput("rdlat3 done", 64'(b_req_done), 64'h2);
                checkRow("rdlat3 wdata", b_wdata, exp_b);
            end
        end
        checkOutput("rdlat3 re cycle", 64'(re_cyc), 64'd1);
        checkOutput("rdlat3 we cycle", 64'(we_cyc), 64'd6);
        checkRow("rdlat3 bram row", mem_b[10'h00C], exp_b);
    endtask

    initial begin
        reset_n     = 1'b0;
        a_req_valid = 2'b00;
        a_req_row   = '0;
        a_req_wd    = '0;
        a_req_tgt   = '0;
        b_req_valid = 2'b00;
        b_req_row   = '0;
        b_req_wd    = '0;
        b_req_tgt   = '0;
        pl_en       = 1'b0;
        pl_sel      = 1'b0;
        pl_row      = '0;
        pl_data     = '0;
        exp_row     = '0;

        vecs[0] = '{0, 10'h005, 5'd7,  32'hDEADBEEF, 32'h11111111, 1'b1};
        vecs[1] = '{0, 10'h008, 5'd0,  32'hCAFEF00D, 32'h22222222, 1'b1};
        vecs[2] = '{1, 10'h009, 5'd31, 32'h12345678, 32'h33333333, 1'b1};
        vecs[3] = '{1, 10'h3FF, 5'd16, 32'hFFFFFFFF, 32'h00000000, 1'b1};
        vecs[4] = '{0, 10'h010, 5'd3,  32'h0000000A, 32'h00000000, 1'b1};
        vecs[5] = '{1, 10'h010, 5'd4,  32'h0000000B, 32'h00000000, 1'b0};
        vecs[6] = '{0, 10'h040, 5'd9,  32'h99999999, 32'h00000000, 1'b0};

        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        checkOutput("reset a busy", 64'(a_busy), 64'd0);
        checkOutput("reset a re", 64'(a_re), 64'd0);
        checkOutput("reset a we", 64'(a_we), 64'd0);
        checkOutput("reset a done", 64'(a_req_done), 64'd0);
        checkOutput("reset a ready", 64'(a_req_ready), 64'd0);
        checkOutput("reset a adr", 64'(a_adr), 64'd0);
        checkOutput("reset b busy", 64'(b_busy), 64'd0);
        checkOutput("reset b adr", 64'(b_adr), 64'd0);

        for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

        runContention();

        runResetMidWrite();
        applyStimulus(vecs[6]);

        runSlowBram();

        $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
